// File: rtl/strobe_timing_gen_if.sv
// Timing-register bundle from the SPI register slave to strobe_timing_gen.
// The master modport is the register slave; the slave modport is the strobe generator.
interface strobe_timing_gen_if;
  logic [15:0] cfg_intclock;
  logic [15:0] cfg_sslowdelay;
  logic [15:0] cfg_sshighdelay;
  logic [15:0] cfg_lampenable;
  logic [15:0] cfg_countbase;
  logic [15:0] cfg_strbcount;

  modport master (
    output cfg_intclock, cfg_sslowdelay, cfg_sshighdelay,
           cfg_lampenable, cfg_countbase, cfg_strbcount
  );

  modport slave (
    input  cfg_intclock, cfg_sslowdelay, cfg_sshighdelay,
           cfg_lampenable, cfg_countbase, cfg_strbcount
  );
endinterface

// File: rtl/strobe_timing_gen.sv
// Integration-period framer with SingleStrobe pulse and ContinuousStrobe square wave.
// Optional macro STROBE_FRAME_COUNT_EN adds a 16-bit frame_count output.
module strobe_timing_gen #(
  parameter int unsigned CLKS_PER_MS = 48000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  strobe_timing_gen_if.slave cfg,
  output logic               int_start,
  output logic               int_active,
  output logic               single_strobe,
  output logic               cont_strobe
`ifdef STROBE_FRAME_COUNT_EN
  ,output logic [15:0]       frame_count
`endif
);

  localparam int unsigned PW = $clog2(CLKS_PER_MS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(CLKS_PER_MS - 2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_q, ms_d;
  logic [15:0]   sh_int_q, sh_int_d;
  logic [15:0]   sh_hi_q, sh_hi_d;
  logic [15:0]   sh_lo_q, sh_lo_d;
  logic          sh_en_q, sh_en_d;
  logic          int_start_q, int_start_d;
  logic          int_active_q, int_active_d;
  logic          ss_q, ss_d;
  logic [15:0]   base_q, base_d;
  logic [15:0]   tick_q, tick_d;
  logic          cs_q, cs_d;
`ifdef STROBE_FRAME_COUNT_EN
  logic [15:0]   frame_count_q, frame_count_d;
`endif

  logic        lamp_on;
  logic [15:0] int_next, cb_eff, sc_eff, ms_next;
  logic        ms_boundary, period_end;
  logic        unused_lamp_bits;

  assign unused_lamp_bits = ^cfg.cfg_lampenable[15:1];

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    lamp_on  = cfg.cfg_lampenable[0];
    int_next = (cfg.cfg_intclock  == 16'd0) ? 16'd1 : cfg.cfg_intclock;
    cb_eff   = (cfg.cfg_countbase == 16'd0) ? 16'd1 : cfg.cfg_countbase;
    sc_eff   = (cfg.cfg_strbcount == 16'd0) ? 16'd1 : cfg.cfg_strbcount;

    // One cycle before each ms boundary: ms_next is the ms index the next cycle belongs to.
    ms_next     = ms_q + 16'd1;
    ms_boundary = (state_q == RUN) && (presc_q == PRESC_PRE);
    period_end  = ms_boundary && (ms_next == sh_int_q);

    state_d  = state_q;
    presc_d  = presc_q;
    ms_d     = ms_q;
    sh_int_d = sh_int_q;
    sh_hi_d  = sh_hi_q;
    sh_lo_d  = sh_lo_q;
    sh_en_d  = sh_en_q;
    ss_d     = ss_q;
    base_d   = base_q;
    tick_d   = tick_q;
    cs_d     = cs_q;

    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        state_d = RUN;
        presc_d = '0;
        ms_d    = '0;
      end
      RUN: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          ms_d    = ms_next;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (period_end) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase

    // Shadows are captured on entry to LOAD so the LOAD cycle's own strobe uses the same values.
    if (state_d == LOAD) begin
      sh_int_d = int_next;
      sh_hi_d  = cfg.cfg_sshighdelay;
      sh_lo_d  = cfg.cfg_sslowdelay;
      sh_en_d  = lamp_on;
      ss_d     = lamp_on && (cfg.cfg_sshighdelay == 16'd0) && (cfg.cfg_sslowdelay != 16'd0);
    end else if (ms_boundary) begin
      if (ms_next == sh_lo_q)
        ss_d = 1'b0;
      else if ((ms_next == sh_hi_q) && sh_en_q && (sh_hi_q < sh_lo_q))
        ss_d = 1'b1;
    end

    if (!lamp_on) begin
      ss_d    = 1'b0;
      sh_en_d = 1'b0;
      base_d  = '0;
      tick_d  = '0;
      cs_d    = 1'b0;
    end else if (base_q >= cb_eff - 16'd1) begin
      base_d = '0;
      if (tick_q >= sc_eff - 16'd1) begin
        tick_d = '0;
        cs_d   = ~cs_q;
      end else begin
        tick_d = tick_q + 16'd1;
      end
    end else begin
      base_d = base_q + 16'd1;
    end

    int_start_d  = (state_d == LOAD);
    int_active_d = (state_d != IDLE);
`ifdef STROBE_FRAME_COUNT_EN
    frame_count_d = (state_q == LOAD) ? frame_count_q + 16'd1 : frame_count_q;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      ms_q          <= '0;
      sh_int_q      <= '0;
      sh_hi_q       <= '0;
      sh_lo_q       <= '0;
      sh_en_q       <= 1'b0;
      int_start_q   <= 1'b0;
      int_active_q  <= 1'b0;
      ss_q          <= 1'b0;
      base_q        <= '0;
      tick_q        <= '0;
      cs_q          <= 1'b0;
`ifdef STROBE_FRAME_COUNT_EN
      frame_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      ms_q          <= ms_d;
      sh_int_q      <= sh_int_d;
      sh_hi_q       <= sh_hi_d;
      sh_lo_q       <= sh_lo_d;
      sh_en_q       <= sh_en_d;
      int_start_q   <= int_start_d;
      int_active_q  <= int_active_d;
      ss_q          <= ss_d;
      base_q        <= base_d;
      tick_q        <= tick_d;
      cs_q          <= cs_d;
`ifdef STROBE_FRAME_COUNT_EN
      frame_count_q <= frame_count_d;
`endif
    end
  end

  assign int_start     = int_start_q;
  assign int_active    = int_active_q;
  assign single_strobe = ss_q;
  assign cont_strobe   = cs_q;
`ifdef STROBE_FRAME_COUNT_EN
  assign frame_count   = frame_count_q;
`endif

endmodule

// File: tb/tb_strobe_timing_gen.sv
// Scoreboard bench for strobe_timing_gen at CLKS_PER_MS=4: stimulus queues expected
// samples by absolute cycle number, a negedge monitor pops and compares them.
module tb_strobe_timing_gen;
  localparam int unsigned CPM = 4;

  typedef enum int {S_START, S_ACTIVE, S_SS, S_CS, S_FC} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic int_start, int_active, single_strobe, cont_strobe;
`ifdef STROBE_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  strobe_timing_gen_if cfg_if ();

  strobe_timing_gen #(.CLKS_PER_MS(CPM)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .cfg           (cfg_if),
    .int_start     (int_start),
    .int_active    (int_active),
    .single_strobe (single_strobe),
    .cont_strobe   (cont_strobe)
`ifdef STROBE_FRAME_COUNT_EN
    ,.frame_count  (frame_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  // Keeps the scoreboard ordered by cycle so the monitor only ever looks at the head.
  task automatic expect_at(input int c, input sig_e s, input logic [15:0] v);
    exp_t e;
    int   i;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    i = sb_q.size();
    while (i > 0 && sb_q[i-1].cyc > c) i--;
    sb_q.insert(i, e);
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      case (e.sig)
        S_START:  act = {15'd0, int_start};
        S_ACTIVE: act = {15'd0, int_active};
        S_SS:     act = {15'd0, single_strobe};
        S_CS:     act = {15'd0, cont_strobe};
`ifdef STROBE_FRAME_COUNT_EN
        S_FC:     act = frame_count;
`endif
        default:  act = 16'hxxxx;
      endcase
      if (e.cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s@%0d: sample missed at cycle %0d", e.sig.name(), e.cyc, cyc);
      end else begin
        check($sformatf("%s@%0d", e.sig.name(), e.cyc), act, e.val);
      end
    end
  end

  initial begin
    cfg_if.cfg_intclock    = 16'd6;
    cfg_if.cfg_sshighdelay = 16'd1;
    cfg_if.cfg_sslowdelay  = 16'd5;
    cfg_if.cfg_lampenable  = 16'd1;
    cfg_if.cfg_countbase   = 16'd3;
    cfg_if.cfg_strbcount   = 16'd2;

    // Reset state, then first periods with LOAD at cycle 6 (first clock after release at 5).
    expect_at(4, S_START, 0);
    expect_at(4, S_ACTIVE, 0);
    expect_at(4, S_SS, 0);
    expect_at(4, S_CS, 0);
    expect_at(5, S_ACTIVE, 0);
    for (int k = 0; k < 3; k++) begin
      expect_at(6 + 24*k,      S_START, 1);
      expect_at(6 + 24*k + 1,  S_START, 0);
      expect_at(6 + 24*k + 23, S_START, 0);
      expect_at(6 + 24*k,      S_SS, 0);
      expect_at(6 + 24*k + 3,  S_SS, 0);
      expect_at(6 + 24*k + 4,  S_SS, 1);
      expect_at(6 + 24*k + 19, S_SS, 1);
      expect_at(6 + 24*k + 20, S_SS, 0);
    end
    expect_at(6,  S_ACTIVE, 1);
    expect_at(40, S_ACTIVE, 1);
    expect_at(10, S_CS, 0);
    expect_at(11, S_CS, 1);
    expect_at(16, S_CS, 1);
    expect_at(17, S_CS, 0);
    expect_at(23, S_CS, 1);
`ifdef STROBE_FRAME_COUNT_EN
    expect_at(6,  S_FC, 16'd0);
    expect_at(7,  S_FC, 16'd1);
    expect_at(31, S_FC, 16'd2);
    expect_at(55, S_FC, 16'd3);
`endif
    to_cycle(5);
    sys_rst_n = 1'b1;

    // Mid-period write at period cycle 10 of the period starting at 54.
    expect_at(78, S_START, 1);
    expect_at(79, S_START, 0);
    expect_at(85, S_START, 0);
    expect_at(86, S_START, 1);
    expect_at(94, S_START, 1);
    expect_at(81, S_SS, 0);
    expect_at(82, S_SS, 1);
    expect_at(85, S_SS, 1);
    expect_at(86, S_SS, 0);
    expect_at(90, S_SS, 1);
    to_cycle(64);
    cfg_if.cfg_intclock = 16'd2;

    // intclock=0 behaves as 1 ms: 4-cycle periods from 102, hi>=int so no pulse.
    expect_at(101, S_SS, 1);
    expect_at(102, S_SS, 0);
    expect_at(104, S_SS, 0);
    expect_at(105, S_SS, 0);
    expect_at(102, S_START, 1);
    expect_at(105, S_START, 0);
    expect_at(106, S_START, 1);
    expect_at(110, S_START, 1);
    to_cycle(100);
    cfg_if.cfg_intclock = 16'd0;

    // hi > lo: no pulse, periods continue.
    expect_at(114, S_START, 1);
    expect_at(137, S_START, 0);
    expect_at(138, S_START, 1);
    expect_at(114, S_SS, 0);
    expect_at(117, S_SS, 0);
    expect_at(126, S_SS, 0);
    expect_at(137, S_SS, 0);
    expect_at(126, S_ACTIVE, 1);
    to_cycle(112);
    cfg_if.cfg_sshighdelay = 16'd3;
    cfg_if.cfg_sslowdelay  = 16'd2;
    cfg_if.cfg_intclock    = 16'd6;

    // Lamp disable during high phases, then re-enable.
    expect_at(162, S_START, 1);
    expect_at(186, S_START, 1);
    expect_at(165, S_SS, 0);
    expect_at(166, S_SS, 1);
    expect_at(169, S_SS, 1);
    expect_at(170, S_SS, 0);
    expect_at(178, S_SS, 0);
    expect_at(185, S_SS, 0);
    expect_at(186, S_SS, 0);
    expect_at(189, S_SS, 0);
    expect_at(190, S_SS, 1);
    expect_at(166, S_CS, 0);
    expect_at(167, S_CS, 1);
    expect_at(169, S_CS, 1);
    expect_at(170, S_CS, 0);
    expect_at(174, S_CS, 0);
    expect_at(180, S_CS, 0);
    expect_at(181, S_CS, 1);
    expect_at(186, S_CS, 1);
    expect_at(187, S_CS, 0);
`ifdef STROBE_FRAME_COUNT_EN
    expect_at(161, S_FC, 16'hFFFF);
    expect_at(162, S_FC, 16'hFFFF);
    expect_at(163, S_FC, 16'h0000);
`endif
    to_cycle(140);
    cfg_if.cfg_sshighdelay = 16'd1;
    cfg_if.cfg_sslowdelay  = 16'd5;
`ifdef STROBE_FRAME_COUNT_EN
    force dut.frame_count_q = 16'hFFFF;
    to_cycle(141);
    release dut.frame_count_q;
`endif
    to_cycle(169);
    cfg_if.cfg_lampenable = 16'd0;
    to_cycle(175);
    cfg_if.cfg_lampenable = 16'd1;

    // Asynchronous reset between edges while both strobes are high.
    expect_at(193, S_SS, 1);
    expect_at(193, S_CS, 1);
    expect_at(193, S_ACTIVE, 1);
    expect_at(194, S_SS, 0);
    expect_at(194, S_CS, 0);
    expect_at(194, S_ACTIVE, 0);
    expect_at(194, S_START, 0);
    expect_at(197, S_ACTIVE, 0);
    expect_at(198, S_START, 1);
    expect_at(198, S_ACTIVE, 1);
    expect_at(201, S_SS, 0);
    expect_at(202, S_SS, 1);
    expect_at(202, S_CS, 0);
    expect_at(203, S_CS, 1);
`ifdef STROBE_FRAME_COUNT_EN
    expect_at(194, S_FC, 16'd0);
    expect_at(199, S_FC, 16'd1);
`endif
    to_cycle(194);
    #2;
    sys_rst_n = 1'b0;
    to_cycle(197);
    sys_rst_n = 1'b1;

    to_cycle(215);
    check("scoreboard_drain", 16'(sb_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
